// File: rtl/kid.sv
// Requester half of the kid/parent handshake: sleeps, cries for food, eats a
// fixed number of bites, then counts the meal and goes back to sleep.
module kid #(
  parameter int HUNGER_TIME = 4,
  parameter int EAT_TIME    = 3,
  parameter int CRY_MAX     = 5
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       food,
  output logic       wakeup,
  output logic       eating,
  output logic       tantrum,
  output logic [7:0] meals
);

  typedef enum logic [1:0] {
    SLEEP = 2'd0,
    CRY   = 2'd1,
    EAT   = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic [7:0] HUNGER_LAST = 8'(HUNGER_TIME - 1);
  localparam logic [7:0] BITE_LAST   = 8'(EAT_TIME - 1);
  localparam logic [7:0] CRY_SAT     = 8'(CRY_MAX);

  state_t     state;
  logic [7:0] hunger_cnt;
  logic [7:0] bite_cnt;
  logic [7:0] cry_cnt;

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // blocking assignments would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      state      <= SLEEP;
      hunger_cnt <= 8'd0;
      bite_cnt   <= 8'd0;
      cry_cnt    <= 8'd0;
      meals      <= 8'd0;
    end else begin
      case (state)
        SLEEP: begin
          if (hunger_cnt == HUNGER_LAST) state <= CRY;
          else                           hunger_cnt <= hunger_cnt + 8'd1;
        end
        CRY: begin
          if (food) begin
            cry_cnt  <= 8'd0;
            bite_cnt <= bite_cnt + 8'd1;
            state    <= (bite_cnt == BITE_LAST) ? FULL : EAT;
          end else if (cry_cnt != CRY_SAT) begin
            cry_cnt <= cry_cnt + 8'd1;
          end
        end
        EAT: begin
          // An interrupted meal keeps its bites and resumes from CRY.
          if (!food)                         state    <= CRY;
          else if (bite_cnt == BITE_LAST)    state    <= FULL;
          else                               bite_cnt <= bite_cnt + 8'd1;
        end
        FULL: begin
          meals      <= meals + 8'd1;
          hunger_cnt <= 8'd0;
          bite_cnt   <= 8'd0;
          cry_cnt    <= 8'd0;
          state      <= SLEEP;
        end
        default: state <= SLEEP;
      endcase
    end
  end

  // Outputs come from registers only, so food never reaches them combinationally.
  assign wakeup  = (state == CRY) || (state == EAT);
  assign eating  = (state == EAT);
  assign tantrum = (cry_cnt == CRY_SAT);

endmodule

// File: tb/tb_kid.sv
// Randomised and directed bench for kid: a behavioural model per instance is
// compared against the DUT on every falling edge, plus literal pin checks.
module tb_kid;

  logic       clk = 1'b0;
  logic       resetb1, food1, wakeup1, eating1, tantrum1;
  logic [7:0] meals1;
  logic       resetb2, food2, wakeup2, eating2, tantrum2;
  logic [7:0] meals2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  kid dut1 (
    .clk(clk), .resetb(resetb1), .food(food1),
    .wakeup(wakeup1), .eating(eating1), .tantrum(tantrum1), .meals(meals1)
  );

  kid #(.HUNGER_TIME(1), .EAT_TIME(1), .CRY_MAX(5)) dut2 (
    .clk(clk), .resetb(resetb2), .food(food2),
    .wakeup(wakeup2), .eating(eating2), .tantrum(tantrum2), .meals(meals2)
  );

  // Behavioural model: the kid's mood plus how long it slept, how many bites
  // it has had, how long it has been crying, and how many meals it finished.
  typedef enum logic [1:0] {M_ASLEEP, M_HUNGRY, M_MEAL, M_STUFFED} mood_e;
  typedef struct packed {
    mood_e mood;
    int    slept;
    int    bites;
    int    cry;
    int    meals;
  } model_t;

  function automatic model_t fresh(int meals);
    model_t m;
    m.mood  = M_ASLEEP;
    m.slept = 0;
    m.bites = 0;
    m.cry   = 0;
    m.meals = meals;
    return m;
  endfunction

  function automatic model_t step(model_t m, bit food, int ht, int et, int cm);
    model_t n = m;
    case (m.mood)
      M_ASLEEP: begin
        n.slept = m.slept + 1;
        if (n.slept >= ht) n.mood = M_HUNGRY;
      end
      M_HUNGRY: begin
        if (food) begin
          n.bites = m.bites + 1;
          n.cry   = 0;
          n.mood  = (n.bites >= et) ? M_STUFFED : M_MEAL;
        end else begin
          n.cry = (m.cry + 1 > cm) ? cm : m.cry + 1;
        end
      end
      M_MEAL: begin
        if (food) begin
          n.bites = m.bites + 1;
          if (n.bites >= et) n.mood = M_STUFFED;
        end else begin
          n.mood = M_HUNGRY;
        end
      end
      default: n = fresh((m.meals + 1) % 256);
    endcase
    return n;
  endfunction

  model_t m1, m2;
  bit     live1 = 1'b0;
  bit     live2 = 1'b0;

  always @(posedge clk) begin
    if (!resetb1) begin
      m1    <= fresh(0);
      live1 <= 1'b1;
    end else if (live1) begin
      m1 <= step(m1, food1, 4, 3, 5);
    end
    if (!resetb2) begin
      m2    <= fresh(0);
      live2 <= 1'b1;
    end else if (live2) begin
      m2 <= step(m2, food2, 1, 1, 5);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live1) begin
      check("dut1.wakeup",  int'(wakeup1),  int'(m1.mood == M_HUNGRY || m1.mood == M_MEAL));
      check("dut1.eating",  int'(eating1),  int'(m1.mood == M_MEAL));
      check("dut1.tantrum", int'(tantrum1), int'(m1.cry == 5));
      check("dut1.meals",   int'(meals1),   m1.meals);
    end
    if (live2) begin
      check("dut2.wakeup",  int'(wakeup2),  int'(m2.mood == M_HUNGRY || m2.mood == M_MEAL));
      check("dut2.eating",  int'(eating2),  int'(m2.mood == M_MEAL));
      check("dut2.tantrum", int'(tantrum2), int'(m2.cry == 5));
      check("dut2.meals",   int'(meals2),   m2.meals);
    end
  end

  task automatic reset_dut1();
    resetb1 = 1'b0;
    food1   = 1'b0;
    @(negedge clk);
    resetb1 = 1'b1;
  endtask

  task automatic wait_wake();
    for (int i = 0; i < 40 && !wakeup1; i++) @(negedge clk);
    check("wake_seen", int'(wakeup1), 1);
  endtask

  initial begin
    bit h1, h2;
    resetb1 = 1'b0; food1 = 1'b0;
    resetb2 = 1'b0; food2 = 1'b0;
    repeat (2) @(negedge clk);

    // Closed loop: food rises one edge after wakeup and lingers two edges after it falls.
    resetb1 = 1'b1;
    h1 = 1'b0; h2 = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e == 3) check("loop.wake_e3", int'(wakeup1), 0);
      if (e == 4) check("loop.wake_e4", int'(wakeup1), 1);
      if (e == 5) check("loop.eat_e5", int'(eating1), 0);
      if (e == 6) check("loop.eat_e6", int'(eating1), 1);
      if (e == 7) check("loop.eat_e7", int'(eating1), 1);
      if (e == 8) check("loop.wake_e8", int'(wakeup1), 0);
      if (e == 8) check("loop.meals_e8", int'(meals1), 0);
      if (e == 9) check("loop.meals_e9", int'(meals1), 1);
      food1 = h1 | h2;
      h2    = h1;
      h1    = wakeup1;
    end

    // Tantrum: cry counter saturates after five hungry cycles.
    reset_dut1();
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (e == 8)  check("tantrum_e8", int'(tantrum1), 0);
      if (e == 9)  check("tantrum_e9", int'(tantrum1), 1);
      if (e == 14) check("tantrum_e14", int'(tantrum1), 1);
      if (e == 14) check("tantrum.meals", int'(meals1), 0);
    end

    // Interrupted meal: food 1,0,1,1 from CRY.
    reset_dut1();
    wait_wake();
    food1 = 1'b1; @(negedge clk); check("intr.eat1", int'(eating1), 1);
    food1 = 1'b0; @(negedge clk); check("intr.cry", int'(eating1), 0);
    check("intr.wake", int'(wakeup1), 1);
    food1 = 1'b1; @(negedge clk); check("intr.eat2", int'(eating1), 1);
    food1 = 1'b1; @(negedge clk); check("intr.full", int'(wakeup1), 0);
    food1 = 1'b0; @(negedge clk); check("intr.meals", int'(meals1), 1);

    // Reset mid-meal discards the bite already taken.
    reset_dut1();
    wait_wake();
    food1 = 1'b1; @(negedge clk); check("mid.eat", int'(eating1), 1);
    resetb1 = 1'b0; @(negedge clk);
    check("mid.wake", int'(wakeup1), 0);
    check("mid.eating", int'(eating1), 0);
    check("mid.meals", int'(meals1), 0);
    resetb1 = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (e == 6) check("mid.eat_e6", int'(eating1), 1);
      if (e == 7) check("mid.full_e7", int'(wakeup1), 0);
      if (e == 8) check("mid.meals_e8", int'(meals1), 1);
    end

    // Random food with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      food1   = ($urandom_range(0, 3) != 0);
      resetb1 = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    resetb1 = 1'b1;

    // Meal counter wrap on the fast instance: one meal every three edges.
    food2   = 1'b1;
    resetb2 = 1'b1;
    for (int e = 1; e <= 770; e++) begin
      @(negedge clk);
      if (e == 765) check("wrap.meals_e765", int'(meals2), 255);
      if (e == 767) check("wrap.meals_e767", int'(meals2), 255);
      if (e == 768) check("wrap.meals_e768", int'(meals2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
